// File: rtl/lsu_ctrl.sv
// Load/store control stage: forwards AGU commands to the DTCM, tracks them in an
// in-order FIFO and routes responses to load write-back or store completion.
// Define LSU_WBCK_REG_EN to put a 1-entry register on the load write-back path.
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 3
`endif

module lsu_ctrl #(
    parameter int OUTS_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        agu_cmd_valid,
    output logic                        agu_cmd_ready,
    input  logic [`DTCM_ADDR_WIDTH-1:0] agu_cmd_addr,
    input  logic                        agu_cmd_read,
    input  logic [`ITAG_WIDTH-1:0]      agu_cmd_itag,
    input  logic [1:0]                  agu_cmd_size,
    input  logic                        agu_cmd_usign,
    input  logic [`XLEN-1:0]            agu_cmd_wdata,
    input  logic [`XLEN/8-1:0]          agu_cmd_wmask,
    output logic                        agu_rsp_valid,
    input  logic                        agu_rsp_ready,
    output logic [`XLEN-1:0]            agu_rsp_rdata,
    output logic                        lsu_wbck_i_valid,
    input  logic                        lsu_wbck_i_ready,
    output logic [`XLEN-1:0]            lsu_wbck_i_data,
    output logic [`ITAG_WIDTH-1:0]      lsu_wbck_i_itag,
    output logic                        dtcm_cmd_valid,
    input  logic                        dtcm_cmd_ready,
    output logic [`DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
    output logic                        dtcm_cmd_read,
    output logic [`XLEN-1:0]            dtcm_cmd_wdata,
    output logic [`XLEN/8-1:0]          dtcm_cmd_wmask,
    input  logic                        dtcm_rsp_valid,
    output logic                        dtcm_rsp_ready,
    input  logic [`XLEN-1:0]            dtcm_rsp_rdata,
    output logic                        lsu_active
);

    localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTS_DEPTH + 1);
    localparam int SLOTS = 1 << PTR_W;

    typedef struct packed {
        logic                   read;
        logic [`ITAG_WIDTH-1:0] itag;
        logic [1:0]             size;
        logic                   usign;
        logic [1:0]             off;
    } outs_t;

    outs_t            r_fifo [SLOTS];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    outs_t            w_head;
    logic [`XLEN-1:0] w_load_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Lane-select then extend; size 3 falls through to the full word.
    function automatic logic [`XLEN-1:0] load_extract(input logic [`XLEN-1:0] rdata,
                                                      input outs_t e);
        logic [`XLEN-1:0] sh;
        logic [`XLEN-1:0] res;
        sh = rdata >> {e.off, 3'b000};
        case (e.size)
            2'd0:    res = {{(`XLEN-8){~e.usign & sh[7]}}, sh[7:0]};
            2'd1:    res = {{(`XLEN-16){~e.usign & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign w_full  = (r_cnt == CNT_W'(OUTS_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[r_rptr];
    assign w_push  = agu_cmd_valid & agu_cmd_ready;
    assign w_pop   = dtcm_rsp_valid & dtcm_rsp_ready;
    assign w_load_data = load_extract(dtcm_rsp_rdata, w_head);

    assign agu_cmd_ready  = dtcm_cmd_ready & ~w_full;
    assign dtcm_cmd_valid = agu_cmd_valid & ~w_full;
    assign dtcm_cmd_addr  = {agu_cmd_addr[`DTCM_ADDR_WIDTH-1:2], 2'b00};
    assign dtcm_cmd_read  = agu_cmd_read;
    assign dtcm_cmd_wdata = agu_cmd_wdata;
    assign dtcm_cmd_wmask = agu_cmd_read ? '0 : agu_cmd_wmask;
    assign agu_rsp_rdata  = '0;

    // NOTE: FIFO payload is not reset; the occupancy counter alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= '{read:  agu_cmd_read,  itag: agu_cmd_itag,
                                size:  agu_cmd_size,  usign: agu_cmd_usign,
                                off:   agu_cmd_addr[1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef LSU_WBCK_REG_EN
    logic                   r_wbck_full;
    logic [`XLEN-1:0]       r_wbck_data;
    logic [`ITAG_WIDTH-1:0] r_wbck_itag;

    // Stores wait while a load sits in the register so completions stay in order.
    always_comb begin
        agu_rsp_valid  = 1'b0;
        dtcm_rsp_ready = 1'b0;
        if (!w_empty) begin
            if (w_head.read) begin
                dtcm_rsp_ready = ~r_wbck_full | lsu_wbck_i_ready;
            end else begin
                agu_rsp_valid  = dtcm_rsp_valid & ~r_wbck_full;
                dtcm_rsp_ready = agu_rsp_ready & ~r_wbck_full;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbck_full <= 1'b0;
            r_wbck_data <= '0;
            r_wbck_itag <= '0;
        end else if (w_pop && w_head.read) begin
            r_wbck_full <= 1'b1;
            r_wbck_data <= w_load_data;
            r_wbck_itag <= w_head.itag;
        end else if (lsu_wbck_i_ready) begin
            r_wbck_full <= 1'b0;
        end
    end

    assign lsu_wbck_i_valid = r_wbck_full;
    assign lsu_wbck_i_data  = r_wbck_data;
    assign lsu_wbck_i_itag  = r_wbck_itag;
    assign lsu_active       = ~w_empty | r_wbck_full;
`else
    always_comb begin
        agu_rsp_valid    = 1'b0;
        dtcm_rsp_ready   = 1'b0;
        lsu_wbck_i_valid = 1'b0;
        lsu_wbck_i_data  = '0;
        lsu_wbck_i_itag  = '0;
        if (!w_empty) begin
            if (w_head.read) begin
                lsu_wbck_i_valid = dtcm_rsp_valid;
                dtcm_rsp_ready   = lsu_wbck_i_ready;
                lsu_wbck_i_data  = w_load_data;
                lsu_wbck_i_itag  = w_head.itag;
            end else begin
                agu_rsp_valid  = dtcm_rsp_valid;
                dtcm_rsp_ready = agu_rsp_ready;
            end
        end
    end

    assign lsu_active = ~w_empty;
`endif

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage directly downstream of the EXU address-generation path. It accepts AGU commands, issues word-aligned accesses to the DTCM and tracks outstanding requests in a small in-order FIFO. DTCM responses are routed back as load write-backs (lane-extracted and sign/zero-extended, tagged with the OITF itag) or as store completions. It sits between the EXU (`agu_cmd_*`, `agu_rsp_*`, `lsu_wbck_*`) and the DTCM port.

## Interface
Parameters:
- OUTS_DEPTH, default 2: outstanding-request FIFO depth; legal values 1..4.

Widths use `XLEN (32), `DTCM_ADDR_WIDTH and `ITAG_WIDTH from defines.v. Clock and reset come first.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  reset is asynchronous and active-high.
- agu_cmd_valid / agu_cmd_ready  in/out  1  command handshake.
- agu_cmd_addr  in  `DTCM_ADDR_WIDTH  byte address.
- agu_cmd_read  in  1  1 = load, 0 = store.
- agu_cmd_itag  in  `ITAG_WIDTH  OITF tag of a load.
- agu_cmd_size  in  2  0 = byte, 1 = half, 2 = word.
- agu_cmd_usign  in  1  zero-extend the load.
- agu_cmd_wdata  in  `XLEN  store data, already lane-aligned.
- agu_cmd_wmask  in  `XLEN/8  store byte enables.
- agu_rsp_valid / agu_rsp_ready  out/in  1  store-completion handshake.
- agu_rsp_rdata  out  `XLEN  always 0.
- lsu_wbck_i_valid / lsu_wbck_i_ready  out/in  1  load write-back handshake.
- lsu_wbck_i_data  out  `XLEN  extended load data.
- lsu_wbck_i_itag  out  `ITAG_WIDTH  tag of the load.
- dtcm_cmd_valid / dtcm_cmd_ready  out/in  1  DTCM command handshake.
- dtcm_cmd_addr  out  `DTCM_ADDR_WIDTH  address with [1:0] forced to 0.
- dtcm_cmd_read  out  1  copy of agu_cmd_read.
- dtcm_cmd_wdata  out  `XLEN  copy of agu_cmd_wdata.
- dtcm_cmd_wmask  out  `XLEN/8  copy of agu_cmd_wmask; 0 for loads.
- dtcm_rsp_valid / dtcm_rsp_ready  in/out  1  DTCM response; in order, at least 1 cycle after the command.
- dtcm_rsp_rdata  in  `XLEN  word read data.
- lsu_active  out  1  FIFO non-empty or output register full.

## Operation
- **Command path.** The command path is combinational.
  - dtcm_cmd_valid = agu_cmd_valid & ~full.
  - agu_cmd_ready = dtcm_cmd_ready & ~full.
- **FIFO push.** On an agu_cmd handshake, push {read, itag, size, usign, addr[1:0]} into the FIFO.
- **FIFO full.** When full, no push is accepted, even if a pop happens in the same cycle.
- **Response routing.** The FIFO head selects the destination:
  - Head read = 1: lsu_wbck_i_valid = dtcm_rsp_valid and dtcm_rsp_ready = lsu_wbck_i_ready.
  - Head read = 0: agu_rsp_valid = dtcm_rsp_valid and dtcm_rsp_ready = agu_rsp_ready.
- **FIFO pop.** Pop on the dtcm_rsp handshake.
- **Empty FIFO.** dtcm_rsp_ready = 0, and both response valids are 0.
- **Load extraction.**
  - Shift rdata right by addr[1:0]*8.
  - size 0: take [7:0]; size 1: take [15:0]; size 2: take the full word.
  - Zero-extend when usign = 1, otherwise sign-extend from the top selected bit.
  - size 3 is treated as word.
- **Alignment.** Misalignment is the AGU's responsibility. The block ignores addr[0] for halfword and addr[1:0] for word accesses; no trap is raised.
- **Simultaneous push and pop.** Allowed when not full; the occupancy is unchanged.
- **Pointer wrap.** Read and write pointers wrap modulo OUTS_DEPTH. Full/empty is decided by a separate occupancy counter, 0..OUTS_DEPTH.

## Timing
- **Reset.** FIFO empty, pointers 0, counter 0, output register empty. As a result:
  - agu_cmd_ready = dtcm_cmd_ready.
  - dtcm_cmd_valid = agu_cmd_valid.
  - agu_rsp_valid = 0, lsu_wbck_i_valid = 0, lsu_active = 0, dtcm_rsp_ready = 0.
  - The output register data and itag are 0.
- **Latency.** With the DTCM at 1-cycle latency and no output register, a load accepted in cycle N presents lsu_wbck_i_valid in cycle N+1.
- **Back-to-back.** One command per cycle is sustained when OUTS_DEPTH ≥ 2.
- **Valid stability.** Response valids stay high until accepted; data is held stable while stalled because the DTCM holds rsp until ready.
- **Reset mid-operation.** Outstanding entries are dropped. DTCM responses arriving after reset is released are ignored, because ready = 0 while the FIFO is empty.

## Configuration
- **LSU_WBCK_REG_EN defined:**
  - Load results pass through a 1-entry output register.
  - dtcm_rsp_ready = ~reg_full | lsu_wbck_i_ready.
  - The FIFO pops when the register loads.
  - Load latency is cycle N+2; a throughput of one load per cycle is kept.
  - Store completions stay unregistered. A store response is held off while the register is full, so store and load responses cannot reorder.
- **LSU_WBCK_REG_EN undefined:** lsu_wbck_i_* is driven combinationally from dtcm_rsp_*, as described under Operation.

## Test plan
- Byte load, signed: addr 0x103, size 0, usign 0, itag 1, rdata 0x80FF_1234 → lsu_wbck_i_data 0xFFFF_FF80, itag 1, in cycle N+1.
- Halfword load, unsigned: addr 0x102, size 1, usign 1, rdata 0x8001_0000 → lsu_wbck_i_data 0x0000_8001.
- Store: addr 0x200, wmask 4'b0011, wdata 0x0000_BEEF:
  - dtcm_cmd_addr 0x200 with the same mask and data.
  - The response produces agu_rsp_valid = 1, agu_rsp_rdata = 0, and no lsu_wbck.
- FIFO full: OUTS_DEPTH 2, two loads issued with dtcm_rsp held low → third command sees agu_cmd_ready = 0.
  - Ready returns the cycle after the first response pops.
- Stall: lsu_wbck_i_ready = 0 for 3 cycles → dtcm_rsp_ready = 0 and data is stable throughout.
  - A following store response is delivered only after the load is accepted.
- Reset: assert rst with 2 entries outstanding → all valids 0 and lsu_active 0 immediately.
  - A late dtcm_rsp_valid after reset is released is not accepted.
